countdown_display_ctrl: RTL and testbench
=========================================

Name: countdown_display_ctrl

Overview:
Sequencer that owns the 4-bit display code (0..10) fed to the team's two-digit seven-segment decoder. Implements a loadable 10-to-0 countdown: load, start, pause/resume, abort, and a one-cycle expiry pulse. A prescaler sets the tick rate. It is the only driver of the decoder's code input; codes 11..15 are used solely to blank the display.

Parameters:
CLKS_PER_TICK, 50000000, clock cycles per countdown step (>=2)
MAX_VAL, 10, saturation limit for loaded values (<=10)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  capture load_val (level-sampled each cycle)
load_val  input  4  start value; values >MAX_VAL saturate to MAX_VAL
start  input  1  begin or resume countdown
pause  input  1  freeze countdown
abort  input  1  return to IDLE, keep current value
disp_code  output  4  code to the seven-segment decoder
running  output  1  high in RUN
paused  output  1  high in PAUSED
expired  output  1  one-cycle pulse on reaching 0

Behaviour:
- One clock. Reset is synchronous and active-high: clk and rst, sampled on the rising edge of clk.
- Reset values: state=IDLE, value=0, prescaler=0, disp_code=0, running=0, paused=0, expired=0. Reset mid-count abandons the count immediately.
- All outputs are registered. disp_code equals value, except as described under Optional Feature.
- Prescaler width is $clog2(CLKS_PER_TICK). The prescaler counts 0..CLKS_PER_TICK-1, then wraps to 0. That wrap is the tick.
- Input priority per cycle: rst > abort > pause > start > load.
- IDLE:
  - load: value <= min(load_val, MAX_VAL).
  - start with value>0: go to RUN and clear the prescaler.
  - start with value==0: go to DONE and assert expired on the next cycle.
- RUN:
  - Prescaler advances each cycle.
  - On a tick, value <= value-1.
  - If the decrement yields 0: go to DONE. expired=1 in the same cycle that disp_code first shows 0.
  - pause: go to PAUSED and freeze the prescaler. If pause coincides with a tick, pause wins and there is no decrement.
  - load is ignored.
- PAUSED:
  - start: go to RUN. The prescaler resumes from its frozen value; it is not cleared.
  - load: updates value (saturated) and stays PAUSED.
- DONE:
  - value holds 0. start is ignored.
  - load: go to IDLE with the new value.
  - The prescaler keeps free-running; this is used only by the optional blink feature.
- abort in any state: go to IDLE, value unchanged, prescaler cleared, expired=0.
- Latency: the first decrement is visible exactly CLKS_PER_TICK cycles after the cycle in which RUN is entered.
- A load of N counts down to expiry in exactly N*CLKS_PER_TICK cycles of uninterrupted RUN.
- running=1 iff state==RUN. paused=1 iff state==PAUSED.
- expired never pulses twice for a single countdown. Its pulse width is exactly 1 cycle.

Optional Feature:
Macro DONE_BLINK_EN.
- Defined: in DONE, disp_code toggles between 0 and 4'hF (decoder blank) on every prescaler tick. It starts at 0 on DONE entry. Leaving DONE restores disp_code=value on the next cycle.
- Undefined: disp_code=value in all states, and no blink logic is generated.

Test Plan:
1. CLKS_PER_TICK=4. rst, load_val=3, load, start -> disp_code 3, then 2, 1, 0 at cycles +4, +8, +12 after RUN entry. expired=1 only at cycle +12. running drops at +12.
2. load_val=13 -> disp_code=10 (saturation). load_val=0 then start -> DONE, expired pulses once, disp_code stays 0.
3. Run from 5, pause at prescaler=2 for 10 cycles, then start -> next decrement occurs 2 cycles after resume. pause on a tick cycle -> no decrement.
4. Run from 7, assert abort mid-count -> IDLE, disp_code holds the current value, running=0, no expired pulse. Assert rst mid-count -> all outputs 0 the next cycle.
5. In DONE: start has no effect. load_val=4 -> IDLE with disp_code=4. load during RUN leaves the value unchanged.
6. With DONE_BLINK_EN defined and CLKS_PER_TICK=4: in DONE, disp_code alternates 0/15 every 4 cycles. A load returns disp_code to the loaded value the next cycle.

Source files
------------

// File: rtl/countdown_display_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_display_ctrl
//
// Owns the 4-bit display code (0..10) that feeds the two-digit seven-segment
// decoder. It implements a loadable countdown with load, start, pause/resume
// and abort controls, plus a one-cycle expiry pulse. A prescaler divides the
// clock down to the countdown step rate.
//
// Optional build macro: DONE_BLINK_EN
//   Defined   : in DONE, disp_code alternates 0 / 4'hF (decoder blank) on every
//               prescaler tick, starting at 0 on DONE entry.
//   Undefined : disp_code always equals the count value.
//
// Parameters:
//   CLKS_PER_TICK : clock cycles per countdown step (>= 2)
//   MAX_VAL       : saturation limit for loaded values (<= 10)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   load      in   capture load_val (level-sampled)
//   load_val  in   [3:0] start value, saturated to MAX_VAL
//   start     in   begin or resume countdown
//   pause     in   freeze countdown
//   abort     in   return to IDLE, keep current value
//   disp_code out  [3:0] code to the seven-segment decoder
//   running   out  high in RUN
//   paused    out  high in PAUSED
//   expired   out  one-cycle pulse when the count reaches 0
//
// Input priority each cycle: rst > abort > pause > start > load.
// -----------------------------------------------------------------------------
module countdown_display_ctrl #(
  parameter int CLKS_PER_TICK = 50000000,
  parameter int MAX_VAL       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] disp_code,
  output logic       running,
  output logic       paused,
  output logic       expired
);

  localparam int PW = $clog2(CLKS_PER_TICK);

  localparam logic [PW-1:0] PSC_LAST = PW'(CLKS_PER_TICK - 1);
  localparam logic [PW-1:0] PSC_ONE  = PW'(32'd1);
  localparam logic [3:0]    MAX_CODE = 4'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_r;
  logic [3:0]    value_r;
  logic [PW-1:0] psc_r;

  logic          tick_s;
  logic [3:0]    sat_val_s;

  // Prescaler wrap marks a countdown step.
  assign tick_s = (psc_r == PSC_LAST);

  // Loaded values above the limit are clamped.
  assign sat_val_s = (load_val > MAX_CODE) ? MAX_CODE : load_val;

  // Countdown FSM with value, prescaler and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      value_r   <= 4'd0;
      psc_r     <= {PW{1'b0}};
      disp_code <= 4'd0;
      running   <= 1'b0;
      paused    <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          psc_r <= {PW{1'b0}};
          if (abort) begin
            state_r <= ST_IDLE;
          end else if (pause) begin
            state_r <= ST_IDLE;
          end else if (start) begin
            if (value_r != 4'd0) begin
              state_r <= ST_RUN;
              running <= 1'b1;
            end else begin
              // Starting from zero expires immediately.
              state_r   <= ST_DONE;
              expired   <= 1'b1;
              disp_code <= 4'd0;
            end
          end else if (load) begin
            value_r   <= sat_val_s;
            disp_code <= sat_val_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (abort) begin
            state_r <= ST_IDLE;
            psc_r   <= {PW{1'b0}};
            running <= 1'b0;
          end else if (pause) begin
            // Pause beats a coincident tick: prescaler and value freeze.
            state_r <= ST_PAUSED;
            running <= 1'b0;
            paused  <= 1'b1;
          end else begin
            psc_r <= tick_s ? {PW{1'b0}} : (psc_r + PSC_ONE);
            if (tick_s) begin
              if (value_r <= 4'd1) begin
                // Expiry pulse lands in the same cycle disp_code shows 0.
                state_r   <= ST_DONE;
                value_r   <= 4'd0;
                disp_code <= 4'd0;
                running   <= 1'b0;
                expired   <= 1'b1;
              end else begin
                value_r   <= value_r - 4'd1;
                disp_code <= value_r - 4'd1;
              end
            end else begin
              state_r <= ST_RUN;
            end
          end
        end

        ST_PAUSED: begin
          if (abort) begin
            state_r <= ST_IDLE;
            psc_r   <= {PW{1'b0}};
            paused  <= 1'b0;
          end else if (pause) begin
            state_r <= ST_PAUSED;
          end else if (start) begin
            paused <= 1'b0;
            if (value_r != 4'd0) begin
              // Resume keeps the frozen prescaler phase.
              state_r <= ST_RUN;
              running <= 1'b1;
            end else begin
              // A zero loaded while paused cannot count; expire instead of wrapping.
              state_r   <= ST_DONE;
              psc_r     <= {PW{1'b0}};
              expired   <= 1'b1;
              disp_code <= 4'd0;
            end
          end else if (load) begin
            value_r   <= sat_val_s;
            disp_code <= sat_val_s;
          end else begin
            state_r <= ST_PAUSED;
          end
        end

        ST_DONE: begin
          // Prescaler free-runs in DONE; only the blink pattern uses it.
          psc_r <= tick_s ? {PW{1'b0}} : (psc_r + PSC_ONE);
`ifdef DONE_BLINK_EN
          if (tick_s) begin
            disp_code <= (disp_code == 4'h0) ? 4'hF : 4'h0;
          end else begin
            disp_code <= disp_code;
          end
`endif
          if (abort) begin
            state_r   <= ST_IDLE;
            psc_r     <= {PW{1'b0}};
            disp_code <= value_r;
          end else if (pause) begin
            state_r <= ST_DONE;
          end else if (start) begin
            state_r <= ST_DONE;
          end else if (load) begin
            state_r   <= ST_IDLE;
            psc_r     <= {PW{1'b0}};
            value_r   <= sat_val_s;
            disp_code <= sat_val_s;
          end else begin
            state_r <= ST_DONE;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          psc_r     <= {PW{1'b0}};
          disp_code <= value_r;
          running   <= 1'b0;
          paused    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_display_ctrl.sv
module tb_countdown_display_ctrl;

  localparam int CPT = 4;
`ifdef DONE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       pause;
  logic       abort;
  logic [3:0] disp_code;
  logic       running;
  logic       paused;
  logic       expired;

  countdown_display_ctrl #(
    .CLKS_PER_TICK(CPT),
    .MAX_VAL      (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .disp_code(disp_code),
    .running  (running),
    .paused   (paused),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] disp;
    logic       run;
    logic       pau;
    logic       exp;
    string      name;
  } exp_t;

  typedef struct {
    logic       load;
    logic [3:0] lv;
    logic       abort;
    logic [3:0] disp;
    string      name;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   checks   = 0;
  int   failures = 0;

  // Expected disp_code d cycles after DONE entry.
  function automatic logic [3:0] done_disp(input int d);
    return (BLINK && (((d / CPT) % 2) == 1)) ? 4'hF : 4'h0;
  endfunction

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if ({disp_code, running, paused, expired} !== {e.disp, e.run, e.pau, e.exp}) begin
      failures++;
      $display("FAIL %s: got disp=%0d run=%0b pau=%0b exp=%0b, expected disp=%0d run=%0b pau=%0b exp=%0b",
               e.name, disp_code, running, paused, expired, e.disp, e.run, e.pau, e.exp);
    end
  endtask

  // Drive one cycle of inputs (at negedge), queue the expectation, compare at next negedge.
  task automatic step(input logic r, input logic l, input logic [3:0] lv,
                      input logic s, input logic p, input logic a,
                      input logic [3:0] ed, input logic er, input logic ep,
                      input logic ee, input string nm);
    exp_t e;
    rst = r; load = l; load_val = lv; start = s; pause = p; abort = a;
    e.disp = ed; e.run = er; e.pau = ep; e.exp = ee; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0; pause = 1'b0; abort = 1'b0;

    tbl[0] = '{load: 1'b1, lv: 4'd3,  abort: 1'b0, disp: 4'd3,  name: "load3"};
    tbl[1] = '{load: 1'b1, lv: 4'd13, abort: 1'b0, disp: 4'd10, name: "sat13"};
    tbl[2] = '{load: 1'b1, lv: 4'd15, abort: 1'b0, disp: 4'd10, name: "sat15"};
    tbl[3] = '{load: 1'b1, lv: 4'd9,  abort: 1'b0, disp: 4'd9,  name: "load9"};
    tbl[4] = '{load: 1'b1, lv: 4'd10, abort: 1'b0, disp: 4'd10, name: "load_max"};
    tbl[5] = '{load: 1'b1, lv: 4'd2,  abort: 1'b1, disp: 4'd10, name: "abort_over_load"};
    tbl[6] = '{load: 1'b0, lv: 4'd7,  abort: 1'b0, disp: 4'd10, name: "idle_hold"};
    tbl[7] = '{load: 1'b1, lv: 4'd0,  abort: 1'b0, disp: 4'd0,  name: "load0"};

    @(negedge clk);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "reset");

    for (int i = 0; i < 8; i++) begin
      step(1'b0, tbl[i].load, tbl[i].lv, 1'b0, 1'b0, tbl[i].abort,
           tbl[i].disp, 1'b0, 1'b0, 1'b0, tbl[i].name);
    end

    // Start from zero: straight to DONE with a single expiry pulse.
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "start_zero");
    for (int d = 1; d <= 5; d++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, done_disp(d), 1'b0, 1'b0, 1'b0, "done_hold");
    end
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, done_disp(6), 1'b0, 1'b0, 1'b0, "done_start_ign");
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "done_load");

    // Countdown from 3; a load during RUN is ignored.
    step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, "load3_run");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, "run_entry");
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, (k == 2), 4'd9, 1'b0, 1'b0, 1'b0,
           4'(3 - k / 4), (k < 12), 1'b0, (k == 12), "countdown3");
    end
    for (int d = 1; d <= 9; d++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, done_disp(d), 1'b0, 1'b0, 1'b0, "done_after_run");
    end
    step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, "done_exit_load");

    // Pause at prescaler=2 for 10 cycles, then resume.
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, "run5_entry");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, "run5_p1");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, "run5_p2");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, "paused_hold");
    end
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, "resume");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, "resume_p1");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, "resume_dec");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, "run4_hold");
    end
    // Pause on the tick cycle: no decrement.
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, "pause_on_tick");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, "pause_on_tick_hold");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, "resume_frozen");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, "frozen_resume_dec");

    // Abort mid-count keeps the value, no expiry.
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, "abort_run");
    step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, "load7");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, "run7_entry");
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'(7 - k / 4), 1'b1, 1'b0, 1'b0, "countdown7");
    end
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, "abort_mid");
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, "abort_idle");
    end

    // Restart after abort: prescaler was cleared, so a full tick period again.
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, "restart_entry");
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, (k < 4) ? 4'd6 : 4'd5, 1'b1, 1'b0, 1'b0, "restart_tick");
    end

    // Reset mid-count clears everything.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "rst_mid");
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
